// File: rtl/regfile_pkg.sv
// Shared constants and the address type for the multi-port register file.
package regfile_pkg;

    localparam int DEF_DATA_W   = 16;
    localparam int DEF_NUM_REGS = 8;
    localparam int DEF_ADDR_W   = $clog2(DEF_NUM_REGS);

    typedef logic [DEF_ADDR_W-1:0] addr_t;

endpackage

// File: rtl/regfile_read_port.sv
// One read port: address range check, stored-data/busy select, optional write bypass.
// Optional feature: REGFILE_MP_BYPASS_EN forwards same-cycle write data and busy state.
module regfile_read_port import regfile_pkg::*; #(
    parameter int  DATA_W   = DEF_DATA_W,
    parameter int  NUM_REGS = DEF_NUM_REGS,
    localparam int ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic                       reset,
    input  logic                       write,
    input  logic [ADDR_W-1:0]          writenum,
    input  logic [DATA_W-1:0]          data_in,
    input  logic                       busy_set,
    input  logic [ADDR_W-1:0]          busy_num,
    input  logic [ADDR_W-1:0]          readnum,
    input  logic [NUM_REGS*DATA_W-1:0] regs,
    input  logic [NUM_REGS-1:0]        busy_vec,
    output logic [DATA_W-1:0]          data_out,
    output logic                       busy
);

    logic              valid_s;
    logic              hit_s;
    logic              hit_busy_s;
    logic [DATA_W-1:0] stored_s;
    logic              stored_busy_s;

    // Select stored state; unimplemented addresses read as zero and not busy
    always_comb begin
        valid_s       = (int'(readnum) < NUM_REGS);
        stored_s      = '0;
        stored_busy_s = 1'b0;
        if (valid_s) begin
            stored_s      = regs[int'(readnum)*DATA_W +: DATA_W];
            stored_busy_s = busy_vec[readnum];
        end else begin
            stored_s      = '0;
            stored_busy_s = 1'b0;
        end
    end

`ifdef REGFILE_MP_BYPASS_EN
    // Reset suppresses forwarding so outputs stay zero while it is held
    assign hit_s      = valid_s && !reset && write && (writenum == readnum);
    assign hit_busy_s = busy_set && (busy_num == readnum);
`else
    logic unused_bypass_s;
    assign hit_s           = 1'b0;
    assign hit_busy_s      = 1'b0;
    assign unused_bypass_s = ^{reset, write, writenum, data_in, busy_set, busy_num};
`endif

    assign data_out = hit_s ? data_in    : stored_s;
    assign busy     = hit_s ? hit_busy_s : stored_busy_s;

endmodule

// File: rtl/regfile_mp.sv
// Register file with one write port, two combinational read ports and a pending-write scoreboard.
// Optional feature: REGFILE_MP_BYPASS_EN enables write-to-read forwarding in the read ports.
module regfile_mp import regfile_pkg::*; #(
    parameter int  DATA_W   = DEF_DATA_W,
    parameter int  NUM_REGS = DEF_NUM_REGS,
    localparam int ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                write,
    input  logic [ADDR_W-1:0]   writenum,
    input  logic [DATA_W-1:0]   data_in,
    input  logic [ADDR_W-1:0]   readnum_a,
    input  logic [ADDR_W-1:0]   readnum_b,
    output logic [DATA_W-1:0]   data_out_a,
    output logic [DATA_W-1:0]   data_out_b,
    input  logic                busy_set,
    input  logic [ADDR_W-1:0]   busy_num,
    output logic                busy_a,
    output logic                busy_b,
    output logic [NUM_REGS-1:0] busy_vec
);

    logic [NUM_REGS*DATA_W-1:0] regs_r;
    logic [NUM_REGS-1:0]        busy_r;
    logic [NUM_REGS-1:0]        busy_next_s;

    // Next pending flags: a set beats a write-clear on the same register
    always_comb begin
        busy_next_s = busy_r;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (busy_set && (busy_num == ADDR_W'(i))) begin
                busy_next_s[i] = 1'b1;
            end else if (write && (writenum == ADDR_W'(i))) begin
                busy_next_s[i] = 1'b0;
            end else begin
                busy_next_s[i] = busy_r[i];
            end
        end
    end

    // Register storage and scoreboard; out-of-range addresses match no entry
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            regs_r <= '0;
            busy_r <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (write && (writenum == ADDR_W'(i))) begin
                    regs_r[i*DATA_W +: DATA_W] <= data_in;
                end
            end
            busy_r <= busy_next_s;
        end
    end

    assign busy_vec = busy_r;

    regfile_read_port #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS)) u_port_a (
        .reset    (reset),
        .write    (write),
        .writenum (writenum),
        .data_in  (data_in),
        .busy_set (busy_set),
        .busy_num (busy_num),
        .readnum  (readnum_a),
        .regs     (regs_r),
        .busy_vec (busy_r),
        .data_out (data_out_a),
        .busy     (busy_a)
    );

    regfile_read_port #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS)) u_port_b (
        .reset    (reset),
        .write    (write),
        .writenum (writenum),
        .data_in  (data_in),
        .busy_set (busy_set),
        .busy_num (busy_num),
        .readnum  (readnum_b),
        .regs     (regs_r),
        .busy_vec (busy_r),
        .data_out (data_out_b),
        .busy     (busy_b)
    );

endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 SHALL have parameter DATA_W, default 16, register width in bits.
REQ-002 SHALL have parameter NUM_REGS, default 8, number of registers (2..32).
REQ-003 SHALL have derived localparam ADDR_W = $clog2(NUM_REGS), address width.
REQ-004 clk  input  1  single clock, all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 write  input  1  write enable for write port.
REQ-007 writenum  input  ADDR_W  write address.
REQ-008 data_in  input  DATA_W  write data.
REQ-009 readnum_a / readnum_b  input  ADDR_W  read addresses, ports A and B.
REQ-010 data_out_a / data_out_b  output  DATA_W  read data, ports A and B.
REQ-011 busy_set  input  1  mark register busy_num as pending (scoreboard set).
REQ-012 busy_num  input  ADDR_W  register to mark pending.
REQ-013 busy_a / busy_b  output  1  pending flag of register addressed by port A / B.
REQ-014 busy_vec  output  NUM_REGS  all pending flags, bit i = register i.

Function
REQ-015 Write: on rising clk with write=1 and writenum<NUM_REGS, register[writenum] SHALL load data_in; all other registers unchanged.
REQ-016 Reads SHALL be combinational, zero latency: data_out_x = register[readnum_x].
REQ-017 Both read ports SHALL be independent; identical addresses on A and B SHALL return identical data.
REQ-018 Scoreboard: on rising clk, busy_set=1 SHALL set busy[busy_num]; write=1 SHALL clear busy[writenum].
REQ-019 Simultaneous busy_set and write to the same register SHALL leave busy set (set wins); data still written.
REQ-020 Simultaneous busy_set and write to different registers SHALL perform both.
REQ-021 busy_set on an already-busy register SHALL leave it busy (no count, no error).
REQ-022 Address >= NUM_REGS (non-power-of-two NUM_REGS): write and busy_set ignored; reads SHALL return 0 data and busy 0.
REQ-023 busy_vec SHALL reflect stored busy bits only, never bypassed values.

Reset
REQ-024 reset=1 SHALL asynchronously clear all registers to 0 and all busy bits to 0, independent of clk.
REQ-025 While reset=1, writes and busy_set SHALL be ignored; outputs SHALL read 0.
REQ-026 Reset asserted in the same cycle as a write SHALL win; register stays 0.

Configuration
REQ-027 Macro REGFILE_MP_BYPASS_EN defined: when write=1 and writenum==readnum_x (valid address), data_out_x SHALL equal data_in combinationally and busy_x SHALL read 0, unless busy_set targets the same register that cycle, in which case busy_x SHALL read 1.
REQ-028 Macro not defined: data_out_x and busy_x SHALL show stored state only; written data visible the cycle after the edge.

Structure
REQ-029 Shared package regfile_pkg SHALL hold default DATA_W/NUM_REGS constants and the address typedef.
REQ-030 One sub-module, regfile_read_port (address decode, out-of-range check, optional bypass mux), SHALL be instantiated once per read port.

Verification
REQ-031 Reset, then write R3=16'hABCD; next cycle readnum_a=3, readnum_b=3 -> both outputs 16'hABCD; other registers 0.
REQ-032 busy_set num=5 -> busy_vec=8'b0010_0000; next cycle write R5=16'h0042 -> busy_vec=0, data_out_a(5)=16'h0042.
REQ-033 Same cycle busy_set num=2 and write R2=16'h1111 -> busy[2]=1, R2=16'h1111.
REQ-034 With REGFILE_MP_BYPASS_EN, write R7=16'hBEEF with readnum_a=7 -> data_out_a=16'hBEEF before edge; without macro -> old value 16'h0000.
REQ-035 Write R1=16'h5555, assert reset mid-cycle (no clk edge) -> data_out_a(1)=0 and busy_vec=0 immediately.
REQ-036 NUM_REGS=6: write addr 7 value 16'hFFFF, busy_set addr 6 -> all registers unchanged, busy_vec=0, read addr 7 -> 0.
